// File: rtl/fp_lnorm.sv
// fp_lnorm: post-add normalizer for the floating-point adder.
// The block takes an unnormalized sum mantissa with an adder carry, guard bit and
// sticky bit. It finds the leading one, shifts the mantissa left (or 1 bit right
// when the adder produced a carry), rounds to nearest-even on guard/sticky, and
// adjusts the exponent. It also flags zero, overflow and underflow results.
// It is a 3-stage pipeline with a global stall enable.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   en                pipeline advance; all stages hold when low
//   valid_i           input qualifier
//   sign_i            sign, passed through unchanged
//   exp_i             biased exponent of the unnormalized sum
//   mant_i            {carry, mantissa[DATAWIDTH-1:0], guard, sticky}
//   valid_o           output qualifier (3 en-cycles after valid_i)
//   sign_o            sign
//   exp_o             normalized exponent
//   mant_o            normalized, rounded mantissa (MSB = hidden bit)
//   zero_o/ovf_o/udf_o  zero, overflow to infinity, underflow flushed to zero
module fp_lnorm #(
    parameter int DATAWIDTH  = 24,
    parameter int EXPWIDTH   = 8,
    parameter int SHIFTWIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   valid_i,
    input  logic                   sign_i,
    input  logic [EXPWIDTH-1:0]    exp_i,
    input  logic [DATAWIDTH+2:0]   mant_i,
    output logic                   valid_o,
    output logic                   sign_o,
    output logic [EXPWIDTH-1:0]    exp_o,
    output logic [DATAWIDTH-1:0]   mant_o,
    output logic                   zero_o,
    output logic                   ovf_o,
    output logic                   udf_o
);

    localparam int W  = DATAWIDTH;
    // Width for the exponent compares, wide enough that exp+1 and exp-lz cannot wrap.
    localparam int CW = (EXPWIDTH >= SHIFTWIDTH) ? EXPWIDTH + 1 : SHIFTWIDTH + 1;
    localparam logic [EXPWIDTH-1:0] EMAX = '1;

    // ---------------- Stage 1: capture + leading-zero count ----------------
    logic [SHIFTWIDTH-1:0] lz_d;
    logic                  s1_valid_q, s1_sign_q;
    logic [EXPWIDTH-1:0]   s1_exp_q;
    logic [W+2:0]          s1_mant_q;
    logic [SHIFTWIDTH-1:0] s1_lz_q;

    // Scanning upward lets the highest set bit win; all-zero leaves W+2.
    always_comb begin
        lz_d = SHIFTWIDTH'(W + 2);
        for (int unsigned i = 0; i < W + 2; i++) begin
            if (mant_i[i]) lz_d = SHIFTWIDTH'(W + 1 - i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_lz_q    <= '0;
        end else if (en) begin
            s1_valid_q <= valid_i;
            s1_sign_q  <= sign_i;
            s1_exp_q   <= exp_i;
            s1_mant_q  <= mant_i;
            s1_lz_q    <= lz_d;
        end
    end

    // ---------------- Stage 2: shift + exponent ----------------
    logic [W+1:0]        shifted;
    logic [CW-1:0]       exp_ext, lz_ext, exp_inc;
    logic [W-1:0]        m2_d, m2_q;
    logic                g2_d, g2_q, st2_d, st2_q;
    logic [EXPWIDTH-1:0] e2_d, e2_q;
    logic                zero2_d, zero2_q, ovf2_d, ovf2_q, udf2_d, udf2_q;
    logic                s2_valid_q, s2_sign_q;

    assign shifted = s1_mant_q[W+1:0] << s1_lz_q;
    assign exp_ext = CW'(s1_exp_q);
    assign lz_ext  = CW'(s1_lz_q);
    assign exp_inc = exp_ext + CW'(1);

    always_comb begin
        m2_d    = '0;
        g2_d    = 1'b0;
        st2_d   = 1'b0;
        e2_d    = '0;
        zero2_d = 1'b0;
        ovf2_d  = 1'b0;
        udf2_d  = 1'b0;
        if (s1_mant_q[W+2]) begin
            m2_d   = s1_mant_q[W+2:3];
            g2_d   = s1_mant_q[2];
            st2_d  = |s1_mant_q[1:0];
            e2_d   = exp_inc[EXPWIDTH-1:0];
            ovf2_d = (exp_inc >= CW'(EMAX));
        end else if (s1_mant_q == '0) begin
            zero2_d = 1'b1;
        end else begin
            m2_d  = shifted[W+1:2];
            g2_d  = shifted[1];
            st2_d = shifted[0];
            if (exp_ext <= lz_ext) begin
                udf2_d = 1'b1;
            end else begin
                // lz < exp here, so the narrowed subtract is exact.
                e2_d = s1_exp_q - EXPWIDTH'(s1_lz_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            m2_q       <= '0;
            g2_q       <= 1'b0;
            st2_q      <= 1'b0;
            e2_q       <= '0;
            zero2_q    <= 1'b0;
            ovf2_q     <= 1'b0;
            udf2_q     <= 1'b0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            m2_q       <= m2_d;
            g2_q       <= g2_d;
            st2_q      <= st2_d;
            e2_q       <= e2_d;
            zero2_q    <= zero2_d;
            ovf2_q     <= ovf2_d;
            udf2_q     <= udf2_d;
        end
    end

    // ---------------- Stage 3: round + final select ----------------
    logic                inc;
    logic [W:0]          rnd;
    logic [CW-1:0]       e_inc;
    logic                ovf_hit;
    logic [W-1:0]        mant_d;
    logic [EXPWIDTH-1:0] exp_d;
    logic                zero_d, ovf_d, udf_d;

    assign inc   = g2_q & (st2_q | m2_q[0]);
    assign rnd   = {1'b0, m2_q} + {{W{1'b0}}, inc};
    assign e_inc = CW'(e2_q) + CW'(1);

    always_comb begin
        mant_d  = rnd[W-1:0];
        exp_d   = e2_q;
        ovf_hit = ovf2_q;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (rnd[W]) begin
            mant_d = {1'b1, {(W-1){1'b0}}};
            exp_d  = e_inc[EXPWIDTH-1:0];
            if (e_inc >= CW'(EMAX)) ovf_hit = 1'b1;
        end
        if (zero2_q) begin
            zero_d = 1'b1;
            mant_d = '0;
            exp_d  = '0;
        end else if (udf2_q) begin
            udf_d  = 1'b1;
            mant_d = '0;
            exp_d  = '0;
        end else if (ovf_hit) begin
            ovf_d  = 1'b1;
            mant_d = '0;
            exp_d  = EMAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            sign_o  <= 1'b0;
            exp_o   <= '0;
            mant_o  <= '0;
            zero_o  <= 1'b0;
            ovf_o   <= 1'b0;
            udf_o   <= 1'b0;
        end else if (en) begin
            valid_o <= s2_valid_q;
            sign_o  <= s2_sign_q;
            exp_o   <= exp_d;
            mant_o  <= mant_d;
            zero_o  <= zero_d;
            ovf_o   <= ovf_d;
            udf_o   <= udf_d;
        end
    end

endmodule

// File: tb/tb_fp_lnorm.sv
// Testbench for fp_lnorm: a floating-point reference model runs against
// directed and randomized stimulus with random stalls and bubbles.
module tb_fp_lnorm;

    localparam int W  = 11;
    localparam int EW = 5;
    localparam int SW = 4;
    localparam int MW = W + 3;
    localparam int EMAX = (1 << EW) - 1;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [W-1:0]  mant;
        logic          zero;
        logic          ovf;
        logic          udf;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          valid_i = 1'b0;
    logic          sign_i = 1'b0;
    logic [EW-1:0] exp_i = '0;
    logic [MW-1:0] mant_i = '0;
    logic          valid_o, sign_o, zero_o, ovf_o, udf_o;
    logic [EW-1:0] exp_o;
    logic [W-1:0]  mant_o;

    int n_chk = 0;
    int n_fail = 0;

    fp_lnorm #(.DATAWIDTH(W), .EXPWIDTH(EW), .SHIFTWIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_i(valid_i), .sign_i(sign_i),
        .exp_i(exp_i), .mant_i(mant_i), .valid_o(valid_o), .sign_o(sign_o),
        .exp_o(exp_o), .mant_o(mant_o), .zero_o(zero_o), .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: treat the input as a plain integer, find its top bit, scale it
    // so the top bit lands on the hidden-bit position, then round half-to-even.
    function automatic res_t model(input logic sg, input int ex, input int unsigned mi);
        res_t r;
        int p, lz, e;
        int unsigned keep, g, st, sh;
        r = '0;
        r.sign = sg;
        if (mi == 0) begin
            r.zero = 1'b1;
            return r;
        end
        p = -1;
        for (int i = 0; i < MW; i++) if (((mi >> i) & 1) != 0) p = i;
        if (p == MW - 1) begin
            keep = mi >> 3;
            g    = (mi >> 2) & 1;
            st   = ((mi & 3) != 0) ? 1 : 0;
            e    = ex + 1;
        end else begin
            lz   = (MW - 2) - p;
            sh   = mi << lz;
            keep = (sh >> 2) & ((1 << W) - 1);
            g    = (sh >> 1) & 1;
            st   = sh & 1;
            e    = ex - lz;
            if (e <= 0) begin
                r.udf = 1'b1;
                return r;
            end
        end
        if (g == 1 && (st == 1 || (keep & 1) == 1)) keep++;
        if (keep == (1 << W)) begin
            keep = 1 << (W - 1);
            e++;
        end
        if (e >= EMAX) begin
            r.ovf = 1'b1;
            r.exp = EW'(EMAX);
        end else begin
            r.mant = W'(keep);
            r.exp  = EW'(e);
        end
        return r;
    endfunction

    // Timing model: three en-qualified slots from input to output.
    logic [2:0] pv = '0;
    res_t       pr[3];
    logic       en_at_edge = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            en_at_edge <= 1'b0;
        end else begin
            en_at_edge <= en;
            if (en) begin
                pv[0] <= valid_i;
                pr[0] <= model(sign_i, int'(exp_i), int'(mant_i));
                pv[1] <= pv[0];
                pr[1] <= pr[0];
                pv[2] <= pv[1];
                pr[2] <= pr[1];
            end
        end
    end

    logic counting = 1'b0;
    int   vcount = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_o", valid_o, pv[2]);
            if (pv[2]) begin
                chk("sign_o", sign_o, pr[2].sign);
                chk("exp_o", exp_o, pr[2].exp);
                chk("mant_o", mant_o, pr[2].mant);
                chk("zero_o", zero_o, pr[2].zero);
                chk("ovf_o", ovf_o, pr[2].ovf);
                chk("udf_o", udf_o, pr[2].udf);
            end
            if (counting && en_at_edge && valid_o) vcount++;
        end
    end

    task automatic drive(input logic v, input logic s, input int unsigned e,
                         input int unsigned m, input logic en_v);
        @(negedge clk);
        #2;
        en      = en_v;
        valid_i = v;
        sign_i  = s;
        exp_i   = EW'(e);
        mant_i  = MW'(m);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_sign"}, sign_o, 0);
        chk({tag, "_exp"}, exp_o, 0);
        chk({tag, "_mant"}, mant_o, 0);
        chk({tag, "_flags"}, {zero_o, ovf_o, udf_o}, 0);
    endtask

    res_t r;
    int unsigned dir_e[10] = '{15, 15, 30, 20, 8, 5, 15, 15, 15, 10};
    int unsigned dir_m[10] = '{'h1000, 'h3000, 'h3FFC, 'h0010, 'h0010, 0,
                               'h1006, 'h1002, 'h1003, 'h1FFE};

    initial begin
        // Reset state
        #12;
        chk_all_zero("reset");
        drive(0, 0, 0, 0, 1);
        rst_n = 1'b1;

        // Hand-computed expectations that pin the reference model
        r = model(0, 15, 'h1000); chk("m_norm", {r.mant, r.exp}, {11'h400, 5'd15});
        r = model(0, 15, 'h3000); chk("m_carry", {r.mant, r.exp}, {11'h600, 5'd16});
        r = model(0, 30, 'h3FFC); chk("m_carry_ovf", {r.ovf, r.mant, r.exp}, {1'b1, 11'h0, 5'd31});
        r = model(0, 20, 'h0010); chk("m_deep", {r.mant, r.exp}, {11'h400, 5'd12});
        r = model(0, 8, 'h0010);  chk("m_udf", {r.udf, r.mant, r.exp}, {1'b1, 11'h0, 5'd0});
        r = model(1, 5, 0);       chk("m_zero", {r.zero, r.sign}, 2'b11);
        r = model(0, 15, 'h1006); chk("m_rne_up", r.mant, 'h402);
        r = model(0, 15, 'h1002); chk("m_rne_tie", r.mant, 'h400);
        r = model(0, 15, 'h1003); chk("m_rne_st", r.mant, 'h401);
        r = model(0, 10, 'h1FFE); chk("m_rnd_carry", {r.mant, r.exp}, {11'h400, 5'd11});

        // Directed vectors back to back
        for (int i = 0; i < 10; i++) drive(1, i[0], dir_e[i], dir_m[i], 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);

        // Stream of 5 with a 2-cycle stall and a bubble
        counting = 1'b1;
        vcount = 0;
        drive(1, 0, 15, 'h1000, 1);
        drive(1, 1, 15, 'h3000, 1);
        drive(1, 0, 20, 'h0111, 0);
        drive(1, 0, 20, 'h0222, 0);
        drive(1, 0, 20, 'h0010, 1);
        drive(0, 1, 9, 'h2AAA, 1);
        drive(1, 1, 15, 'h1006, 1);
        drive(1, 0, 10, 'h1FFE, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        counting = 1'b0;
        chk("stream_count", vcount, 5);

        // Reset with 3 items in flight
        drive(1, 1, 15, 'h1000, 1);
        drive(1, 0, 20, 'h0010, 1);
        drive(1, 1, 15, 'h3000, 1);
        drive(0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        drive(0, 0, 0, 0, 1);
        rst_n = 1'b1;
        counting = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1);
        counting = 1'b0;
        chk("post_reset_count", vcount, 0);

        // Randomized stream with stalls and bubbles
        for (int i = 0; i < 2000; i++) begin
            int unsigned m;
            m = ($urandom & 32'h3FFF) >> $urandom_range(0, 13);
            if ($urandom_range(0, 19) == 0) m = 0;
            drive(($urandom % 100) < 85, $urandom_range(0, 1), $urandom_range(1, 30), m,
                  ($urandom % 100) < 80);
        end
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
